// File: rtl/fp_halve_seq.sv
// rtl/fp_halve_seq.sv - sequential FP halving controller driving a combinational shift unit
// One halving per clock through the external unit; valid/ready on command and result sides.
module fp_halve_seq #(
  parameter int         CNT_W     = 5,
  parameter logic [3:0] OP_RSHIFT = 4'd8,
  parameter logic [3:0] OP_IDLE   = 4'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_underflow,
  output logic [31:0]      unit_a,
  output logic [3:0]       unit_op,
  input  logic [31:0]      unit_out,
  input  logic             unit_uf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [31:0]        acc;
  logic [CNT_W-1:0]   cnt;
  logic               uf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      uf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            acc <= cmd_data;
            cnt <= cmd_count;
            uf  <= 1'b0;
            // Zero count and Inf/NaN operands skip the unit entirely
            if (cmd_count == '0 || cmd_data[30:23] == 8'hFF)
              state <= DONE;
            else
              state <= RUN;
          end
        end
        RUN: begin
          acc <= unit_out;
          uf  <= uf | unit_uf;
          cnt <= cnt - CNT_W'(1);
          // Underflow pins the value at the minimum denormal, so further steps are pointless
          if (cnt == CNT_W'(1) || unit_uf)
            state <= DONE;
        end
        DONE: begin
          if (res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state == IDLE);
  assign res_valid     = (state == DONE);
  assign res_data      = acc;
  assign res_underflow = uf;
  assign unit_a        = acc;
  assign unit_op       = (state == RUN) ? OP_RSHIFT : OP_IDLE;

endmodule

// File: tb/tb_fp_halve_seq.sv
// tb/tb_fp_halve_seq.sv - self-checking bench for fp_halve_seq with a behavioural shift unit
module tb_fp_halve_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic [4:0]  cmd_count;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_underflow;
  logic [31:0] unit_a;
  logic [3:0]  unit_op;
  logic [31:0] unit_out;
  logic        unit_uf;
  logic [31:0] model_out;
  logic        model_uf;
  logic        noise_uf = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_halve_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_underflow(res_underflow),
    .unit_a(unit_a), .unit_op(unit_op), .unit_out(unit_out), .unit_uf(unit_uf)
  );

  // Returns {uf, result}: value/2 with truncation, pinned to the minimum denormal on underflow
  function automatic logic [32:0] halve(input logic [31:0] a);
    logic       s;
    logic [7:0] e;
    logic [22:0] f;
    s = a[31]; e = a[30:23]; f = a[22:0];
    if (e == 8'hFF)      return {1'b0, a};
    else if (e > 8'd1)   return {1'b0, s, e - 8'd1, f};
    else if (e == 8'd1)  return {1'b0, s, 8'd0, 1'b1, f[22:1]};
    else if (f <= 23'd1) return {1'b1, s, 8'd0, 23'd1};
    else                 return {1'b0, s, 8'd0, 1'b0, f[22:1]};
  endfunction

  always_comb begin
    {model_uf, model_out} = halve(unit_a);
    unit_out = (unit_op == 4'd8) ? model_out : unit_a;
    unit_uf  = (unit_op == 4'd8) ? model_uf : noise_uf;
  end

  // The flag outside stepping is garbage that must be ignored
  always @(negedge clk) noise_uf <= 1'($urandom_range(0, 1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; pend drives a second command during the DONE wait
  task automatic run_cmd(input logic [31:0] d, input logic [4:0] n, input int hold,
                         input bit pend, input logic [31:0] pd, input logic [4:0] pn);
    logic [31:0] vals[$];
    logic        exp_uf;
    logic [32:0] h;
    int          k;
    int          cyc;
    vals.delete();
    vals.push_back(d);
    exp_uf = 1'b0;
    k = 0;
    if (n != 5'd0 && d[30:23] != 8'hFF) begin
      for (int i = 0; i < int'(n); i++) begin
        h = halve(vals[i]);
        vals.push_back(h[31:0]);
        k++;
        if (h[32]) begin
          exp_uf = 1'b1;
          break;
        end
      end
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_data = d; cmd_count = n;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = $urandom; cmd_count = 5'($urandom);
    cyc = 1;
    while (!res_valid && cyc <= 40) begin
      check("unit_op_run", 32'(unit_op), 32'd8);
      check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (cyc - 1 < vals.size()) check("acc_step", unit_a, vals[cyc-1]);
      else check("step_overrun", cyc, k + 1);
      @(negedge clk);
      cyc++;
    end
    check("res_valid", 32'(res_valid), 32'd1);
    check("latency", cyc, k + 1);
    check("res_data", res_data, vals[k]);
    check("res_uf", 32'(res_underflow), 32'(exp_uf));
    check("unit_op_done", 32'(unit_op), 32'd0);
    if (pend) begin
      cmd_valid = 1'b1; cmd_data = pd; cmd_count = pn;
    end
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", res_data, vals[k]);
      check("hold_uf", 32'(res_underflow), 32'(exp_uf));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_res_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        seen;
    rst = 1'b1; res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_data = 32'h3F800000; cmd_count = 5'd3;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_uf", 32'(res_underflow), 32'd0);
    check("rst_unit_op", 32'(unit_op), 32'd0);
    check("rst_unit_a", unit_a, 32'd0);
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_no_accept", 32'(res_valid), 32'd0);

    run_cmd(32'h40800000, 5'd2, 0, 1'b0, 32'd0, 5'd0);
    run_cmd(32'hC0400000, 5'd0, 0, 1'b0, 32'd0, 5'd0);
    run_cmd(32'h00000004, 5'd5, 0, 1'b0, 32'd0, 5'd0);
    run_cmd(32'h7F800000, 5'd4, 0, 1'b0, 32'd0, 5'd0);
    run_cmd(32'h3F800000, 5'd3, 5, 1'b1, 32'h40000000, 5'd4);
    run_cmd(32'h40000000, 5'd4, 0, 1'b0, 32'd0, 5'd0);

    // Reset in the middle of a 10-step command
    cmd_valid = 1'b1; cmd_data = 32'h40800000; cmd_count = 5'd10;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_unit_op", 32'(unit_op), 32'd0);
    check("midrst_acc", unit_a, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid || !cmd_ready) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);

    for (int t = 0; t < 40; t++) begin
      rd = $urandom;
      case ($urandom_range(0, 3))
        0: rd[30:23] = 8'($urandom_range(0, 3));
        1: rd[30:23] = 8'hFF;
        2: rd = {rd[31], 8'd0, 18'd0, rd[4:0]};
        default: ;
      endcase
      run_cmd(rd, 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 1'b0, 32'd0, 5'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
